// File: rtl/reg_depth_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : reg_depth_sweep_gen
// Brief    : Synthesizable write/read-back sweep generator for a registered
//            memory target. Two passes (pattern, inverted pattern) over
//            every location, with a READ_LAT-deep compare pipeline, a
//            saturating error counter and first-failing-address capture.
// Revision : 1.0 - initial release
// ============================================================================
module reg_depth_sweep_gen #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 2**ADDR_W,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned SEED     = 32'hA5
) (
  input  logic              clk,
  input  logic              rst,             // asynchronous, active-low
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              clken,
  input  logic [DATA_W-1:0] qout
);

  localparam logic [DATA_W-1:0] C_SEED = DATA_W'(SEED);
  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);
  localparam int unsigned       C_FW   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [C_FW-1:0]   C_FLUSH_LAST = C_FW'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_FLUSH = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t              state_q;
  logic                pass_idx_q;
  logic [C_FW-1:0]     flush_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                clken_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [15:0]         err_cnt_q;
  logic [15:0]         err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q;
  logic [ADDR_W-1:0]   first_err_d;

  // Compare pipeline: one entry per presented read address
  logic                pv_q [READ_LAT];
  logic [ADDR_W-1:0]   pa_q [READ_LAT];
  logic [DATA_W-1:0]   pe_q [READ_LAT];

  logic                w_start_ok;
  logic                w_mismatch;

  // Pattern f(a) = SEED + a (mod 2**DATA_W), optionally inverted for pass 1
  function automatic logic [DATA_W-1:0] f_pat(input logic [ADDR_W-1:0] a,
                                               input logic             inv);
    logic [DATA_W-1:0] v;
    v = C_SEED + DATA_W'(a);
    return inv ? ~v : v;
  endfunction

  assign w_start_ok = (state_q == S_IDLE) && start;
  assign w_mismatch = pv_q[READ_LAT-1] && (qout != pe_q[READ_LAT-1]);

  // Error accounting: cleared on launch, otherwise saturating count and
  // first-address capture (err_cnt never wraps, so zero means "no error yet")
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    if (w_start_ok) begin
      err_cnt_d   = '0;
      first_err_d = '0;
    end else if (w_mismatch) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0)    first_err_d = pa_q[READ_LAT-1];
    end
  end

  // Shift the valid/address/expected pipeline; a new entry enters every RD cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pa_q[i] <= '0;
        pe_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= (state_q == S_RD);
      pa_q[0] <= addr_q;
      pe_q[0] <= f_pat(addr_q, pass_idx_q);
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  // Sweep sequencer with registered target-side and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pass_idx_q  <= 1'b0;
      flush_cnt_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      clken_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_WR;
            pass_idx_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= f_pat('0, 1'b0);
            clken_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        S_WR: begin
          if (addr_q == C_LAST) begin
            state_q <= S_RD;
            addr_q  <= '0;
            clken_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
            data_q <= f_pat(addr_q + 1'b1, pass_idx_q);
          end
        end
        S_RD: begin
          // addr holds at the last location through FLUSH
          if (addr_q == C_LAST) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= '0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt_q == C_FLUSH_LAST) begin
            if (!pass_idx_q) begin
              state_q    <= S_WR;
              pass_idx_q <= 1'b1;
              addr_q     <= '0;
              data_q     <= f_pat('0, 1'b1);
              clken_q    <= 1'b1;
            end else begin
              state_q <= S_FIN;
            end
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        S_FIN: begin
          // The final compare has already landed in err_cnt_q here
          state_q <= S_IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (err_cnt_q == 16'd0);
        end
        default: begin
          state_q <= S_IDLE;
          clken_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign addr           = addr_q;
  assign data           = data_q;
  assign clken          = clken_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_depth_sweep_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_depth_sweep_gen
// Brief    : Directed bench for reg_depth_sweep_gen. Instance A uses
//            READ_LAT=1 against a memory model with ideal / stuck-bit /
//            extra-latency modes; instance B uses READ_LAT=3 with an optional
//            single read corruption.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_depth_sweep_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         tests = 0;
  int         failed = 0;
  int         n_a = 0;
  int         n_b = 0;

  // Instance A signals and memory model
  logic       start_a = 1'b0;
  logic       busy_a, done_a, pass_a, clken_a;
  logic [15:0] err_a;
  logic [3:0] ferr_a, addr_a;
  logic [7:0] data_a, qout_a;
  logic [7:0] mem_a [16];
  logic [7:0] rd_a1, rd_a2;
  int         mode_a = 0;   // 0 ideal, 1 bit3 stuck-at-0, 2 two-cycle read

  // Instance B signals and memory model
  logic       start_b = 1'b0;
  logic       busy_b, done_b, pass_b, clken_b;
  logic [15:0] err_b;
  logic [3:0] ferr_b, addr_b;
  logic [7:0] data_b, qout_b;
  logic [7:0] mem_b [16];
  logic [7:0] rd_b1, rd_b2, rd_b3;
  logic       corrupt_b = 1'b0;

  always #5 clk = ~clk;

  reg_depth_sweep_gen #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .READ_LAT(1), .SEED(32'hA5)) u_dut_a (
    .clk(clk), .rst(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .first_err_addr(ferr_a), .addr(addr_a),
    .data(data_a), .clken(clken_a), .qout(qout_a)
  );

  reg_depth_sweep_gen #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .READ_LAT(3), .SEED(32'hA5)) u_dut_b (
    .clk(clk), .rst(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .first_err_addr(ferr_b), .addr(addr_b),
    .data(data_b), .clken(clken_b), .qout(qout_b)
  );

  // Memory A: registered read, optional stuck bit, optional extra read stage
  always @(posedge clk) begin
    if (clken_a) mem_a[addr_a] <= (mode_a == 1) ? (data_a & 8'hF7) : data_a;
    rd_a1 <= mem_a[addr_a];
    rd_a2 <= rd_a1;
  end
  assign qout_a = (mode_a == 2) ? rd_a2 : rd_a1;

  // Memory B: three-stage read; corrupts the pass-1 read of address 9
  always @(posedge clk) begin
    if (clken_b) mem_b[addr_b] <= data_b;
    rd_b1 <= mem_b[addr_b] ^ ((corrupt_b && !clken_b && addr_b == 4'd9 && mem_b[9] == 8'h51) ? 8'h01 : 8'h00);
    rd_b2 <= rd_b1;
    rd_b3 <= rd_b2;
  end
  assign qout_b = rd_b3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on A for one edge; n_a counts edges after the accepting edge
  task automatic launch_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n_a = 0;
  endtask

  task automatic wait_done_a();
    while (!done_a && n_a < 300) begin
      tick();
      n_a++;
    end
  endtask

  task automatic launch_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n_b = 0;
  endtask

  task automatic wait_done_b();
    while (!done_b && n_b < 300) begin
      tick();
      n_b++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_done",  32'(done_a),  32'd0);
    check("rst_pass",  32'(pass_a),  32'd0);
    check("rst_err",   32'(err_a),   32'd0);
    check("rst_ferr",  32'(ferr_a),  32'd0);
    check("rst_addr",  32'(addr_a),  32'd0);
    check("rst_data",  32'(data_a),  32'd0);
    check("rst_clken", 32'(clken_a), 32'd0);

    // Ideal run with a stray start pulse at WR cycle 3 (ignored)
    mode_a = 0;
    launch_a();
    check("wr0_clken", 32'(clken_a), 32'd1);
    check("wr0_addr",  32'(addr_a),  32'd0);
    check("wr0_data",  32'(data_a),  32'hA5);
    check("wr0_busy",  32'(busy_a),  32'd1);
    repeat (3) begin tick(); n_a++; end
    start_a = 1'b1;
    tick(); n_a++;
    start_a = 1'b0;
    check("wr4_data",  32'(data_a),  32'hA9);
    repeat (11) begin tick(); n_a++; end
    check("wr15_addr", 32'(addr_a),  32'd15);
    check("wr15_data", 32'(data_a),  32'hB4);
    tick(); n_a++;
    check("rd0_clken", 32'(clken_a), 32'd0);
    check("rd0_addr",  32'(addr_a),  32'd0);
    check("rd0_data",  32'(data_a),  32'hB4);
    repeat (17) begin tick(); n_a++; end
    check("p1wr0_clken", 32'(clken_a), 32'd1);
    check("p1wr0_data",  32'(data_a),  32'h5A);
    repeat (15) begin tick(); n_a++; end
    check("p1wr15_data", 32'(data_a),  32'h4B);
    check("busy_mid",    32'(busy_a),  32'd1);
    check("done_mid",    32'(done_a),  32'd0);
    wait_done_a();
    check("ideal_lat",  32'(n_a),    32'd67);
    check("ideal_pass", 32'(pass_a), 32'd1);
    check("ideal_err",  32'(err_a),  32'd0);
    check("ideal_ferr", 32'(ferr_a), 32'd0);
    check("ideal_busy", 32'(busy_a), 32'd0);

    // Bit 3 stuck at 0: every address fails in exactly one polarity
    mode_a = 1;
    launch_a();
    check("stuck_done_clr", 32'(done_a), 32'd0);
    wait_done_a();
    check("stuck_lat",  32'(n_a),    32'd67);
    check("stuck_err",  32'(err_a),  32'd16);
    check("stuck_ferr", 32'(ferr_a), 32'd3);
    check("stuck_pass", 32'(pass_a), 32'd0);

    // Target one cycle slower than READ_LAT: every compare mismatches
    mode_a = 2;
    launch_a();
    wait_done_a();
    check("lat2_err",  32'(err_a),  32'd32);
    check("lat2_ferr", 32'(ferr_a), 32'd0);
    check("lat2_pass", 32'(pass_a), 32'd0);

    // Asynchronous reset in pass 0 WR at addr 5
    mode_a = 0;
    launch_a();
    repeat (5) tick();
    check("arst_pre_addr", 32'(addr_a), 32'd5);
    rst_n = 1'b0;
    #1;
    check("arst_clken", 32'(clken_a), 32'd0);
    check("arst_busy",  32'(busy_a),  32'd0);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("arst_idle_clken", 32'(clken_a), 32'd0);
    check("arst_idle_busy",  32'(busy_a),  32'd0);
    check("arst_idle_done",  32'(done_a),  32'd0);
    check("arst_idle_err",   32'(err_a),   32'd0);
    check("arst_idle_addr",  32'(addr_a),  32'd0);
    launch_a();
    wait_done_a();
    check("arst_rerun_lat",  32'(n_a),    32'd67);
    check("arst_rerun_pass", 32'(pass_a), 32'd1);

    // Start held high through FIN relaunches from IDLE
    launch_a();
    repeat (64) begin tick(); n_a++; end
    start_a = 1'b1;
    wait_done_a();
    check("hold_lat",   32'(n_a),     32'd67);
    check("hold_done",  32'(done_a),  32'd1);
    check("hold_busy0", 32'(busy_a),  32'd0);
    tick();
    start_a = 1'b0;
    n_a = 0;
    check("hold_done_clr", 32'(done_a),  32'd0);
    check("hold_busy1",    32'(busy_a),  32'd1);
    check("hold_clken",    32'(clken_a), 32'd1);
    wait_done_a();
    check("hold2_lat",  32'(n_a),    32'd67);
    check("hold2_pass", 32'(pass_a), 32'd1);

    // READ_LAT=3 instance: ideal run, then a single corrupted read
    launch_b();
    wait_done_b();
    check("b_lat",  32'(n_b),    32'd71);
    check("b_pass", 32'(pass_b), 32'd1);
    check("b_err",  32'(err_b),  32'd0);
    corrupt_b = 1'b1;
    launch_b();
    wait_done_b();
    corrupt_b = 1'b0;
    check("bc_lat",  32'(n_b),    32'd71);
    check("bc_err",  32'(err_b),  32'd1);
    check("bc_ferr", 32'(ferr_b), 32'd9);
    check("bc_pass", 32'(pass_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_depth_sweep_gen.md
Name: reg_depth_sweep_gen

Overview:
- Self-checking stimulus and response stage placed directly upstream of the register-depth target `rtl_top`.
- Drives `addr`/`data`/`clken` into the target and consumes `qout`.
- Sweeps every location twice: pass 0 writes pattern f(a), pass 1 writes ~f(a). This exercises every bit in both polarities for the lossless-depth check.
- Replaces the open-loop testbench task with synthesizable, cycle-exact sequencing and reports pass/fail, error count and first failing address.

Parameters:
- ADDR_W, 8, target address width.
- DATA_W, 8, target data width.
- DEPTH, 2**ADDR_W, number of locations swept (1..2**ADDR_W).
- READ_LAT, 1, cycles from `addr` presented (`clken`=0) to valid `qout` (1..4).
- SEED, 8'hA5, pattern seed, truncated or zero-extended to DATA_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to run a sweep; sampled only in IDLE.
- busy  output  1  high from the cycle after `start` is accepted until `done` rises.
- done  output  1  sticky; set when the sweep completes, cleared by the next accepted `start`.
- pass  output  1  valid when `done`=1; 1 iff err_cnt==0.
- err_cnt  output  16  number of mismatching compares; saturates at 16'hFFFF.
- first_err_addr  output  ADDR_W  address of the first mismatch; 0 if none.
- addr  output  ADDR_W  target address.
- data  output  DATA_W  target write data.
- clken  output  1  target write enable (1 = write `data` to `addr` on this edge).
- qout  input  DATA_W  target read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - addr=0, data=0, clken=0.
  - busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0.
  - Compare pipeline valid bits are cleared.
  - Reset mid-sweep aborts immediately with no further target writes. After release the block stays in IDLE until a new `start`.
- Pattern:
  - f(a) = (SEED + a) mod 2**DATA_W, where a is zero-extended.
  - Pass 0 expects f(a); pass 1 expects ~f(a).
- FSM states: IDLE, WR, RD, FLUSH, FIN.
  - IDLE: on start=1, clear err_cnt, first_err_addr, done and pass; set pass_idx=0, addr=0; go to WR. busy=1 from the next cycle.
  - WR: clken=1, data=pattern(addr). addr increments each cycle. After addr==DEPTH-1 is written, addr=0 and go to RD. Lasts DEPTH cycles.
  - RD: clken=0, data holds its last value. addr increments each cycle. Each presented address, with its expected value, enters a READ_LAT-deep valid/expected shift pipeline. After addr==DEPTH-1, go to FLUSH. Lasts DEPTH cycles.
  - FLUSH: lasts READ_LAT cycles and drains the compare pipeline.
    - If pass_idx==0: set pass_idx=1, addr=0, go to WR.
    - Otherwise go to FIN.
  - FIN: done=1, busy=0, pass=(err_cnt==0); next state IDLE.
- Compare: when a pipeline entry exits valid, qout is compared against the expected value.
  - On mismatch, err_cnt increments (saturating).
  - If this is the first mismatch of the run, first_err_addr captures the entry's address.
- Latency: `done` rises 2*(2*DEPTH+READ_LAT)+1 cycles after the `start` edge.
- Boundaries:
  - `start` is ignored while busy=1 or in FIN.
  - `start` held high re-launches from IDLE after FIN, and clears done on acceptance.
  - DEPTH<2**ADDR_W: addresses DEPTH..2**ADDR_W-1 are never driven.
  - addr wraps to 0 only through the explicit state transitions, never by overflow.
  - When a compare completes in the same cycle the FSM leaves FLUSH, that compare is counted before FIN evaluates `pass`.

Test Plan:
- ADDR_W=4, DEPTH=16, DATA_W=8, SEED=8'hA5, READ_LAT=1, ideal memory model. Pulse start -> 16 writes with data A5..B4, then 16 reads, then 16 writes with 5A..4B, then 16 reads. done=1 at cycle 67 after start, pass=1, err_cnt=0.
- Same setup, model bit 3 of storage stuck-at-0 -> err_cnt=16 (each address fails in exactly one pass), first_err_addr=3 (f(3)=A8), pass=0.
- Model read latency 2 with READ_LAT=1 -> err_cnt=32 (every location in both passes mismatches, since consecutive patterns differ), first_err_addr=0, pass=0.
- Assert rst=0 during pass 0 WR at addr=5 -> clken=0 and busy=0 in the same cycle (asynchronous). After release, outputs hold reset values; a fresh start completes a clean pass=1.
- Pulse start at WR cycle 3 -> ignored, and done timing is unchanged. Hold start high through FIN -> a second run begins on the cycle after FIN, done clears, and busy rises on the following cycle.
- Ideal model with READ_LAT=3 -> done at cycle 2*(32+3)+1=71, pass=1. Force a single qout corruption at pass 1 addr 9 -> err_cnt=1, first_err_addr=9.
